// File: rtl/operand_stack.sv
// -----------------------------------------------------------------------------
// operand_stack
//
// Purpose:
//    Operand stack for a small stack machine. It supports PUSH, POP and NOP,
//    and EXEC, which sends the top one or two entries to an external
//    combinational ALU and writes the result back onto the stack.
//    EXEC passes through IDLE -> EXEC -> WRITE -> IDLE. Each illegal command is
//    rejected when it is accepted. A rejected command leaves the stack
//    unchanged and produces an error pulse and an error code.
//
// Ports:
//    clk          single clock, rising edge
//    rst_n        asynchronous active-low reset
//    cmd_valid    a command is offered
//    cmd_ready    a command can be accepted (only in IDLE)
//    cmd          0=NOP 1=PUSH 2=POP 3=EXEC
//    push_data    value written on PUSH
//    cmd_opcode   ALU opcode used on EXEC (4..13 valid, 13 = NOT)
//    alu_a/alu_b  registered ALU operands
//    alu_opcode   registered ALU opcode
//    alu_result   combinational ALU output
//    top          top-of-stack value, 0 when empty
//    count        number of valid entries
//    err          one-cycle error pulse
//    err_code     0=none 1=overflow 2=underflow 3=bad opcode, held until the
//                 next accepted command
// -----------------------------------------------------------------------------
module operand_stack #(
   parameter int DATA_SIZE = 11,
   parameter int DEPTH     = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd,
   input  logic [DATA_SIZE-1:0]         push_data,
   input  logic [3:0]                   cmd_opcode,
   output logic [DATA_SIZE-1:0]         alu_a,
   output logic [DATA_SIZE-1:0]         alu_b,
   output logic [3:0]                   alu_opcode,
   input  logic [DATA_SIZE-1:0]         alu_result,
   output logic [DATA_SIZE-1:0]         top,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         err,
   output logic [1:0]                   err_code
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   localparam logic [1:0] CMD_PUSH = 2'd1;
   localparam logic [1:0] CMD_POP  = 2'd2;
   localparam logic [1:0] CMD_EXEC = 2'd3;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_OVF   = 2'd1;
   localparam logic [1:0] ERR_UNF   = 2'd2;
   localparam logic [1:0] ERR_BADOP = 2'd3;

   localparam logic [3:0] OP_FIRST = 4'd4;
   localparam logic [3:0] OP_LAST  = 4'd13;
   localparam logic [3:0] OP_NOT   = 4'd13;

   typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;

   state_t               state;
   logic [DATA_SIZE-1:0] mem [DEPTH];
   logic [DATA_SIZE-1:0] result_q;
   logic [AW-1:0]        top_idx;
   logic [AW-1:0]        sec_idx;
   logic [AW-1:0]        push_idx;
   logic                 accept;
   logic                 cmd_not;
   logic                 push_ok;
   logic [1:0]           check_code;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // Pointers into storage. They are only used when count is large enough
   // for them to be meaningful, so the wrap of count-1 at count==0 is harmless.
   assign top_idx  = AW'(count - CW'(1));
   assign sec_idx  = top_idx - AW'(1);
   assign push_idx = count[AW-1:0];

   // Check the offered command against the current occupancy. A nonzero code
   // means the command is rejected, and the stack and FSM stay untouched.
   // A bad opcode takes precedence over an operand shortage.
   always_comb begin
      check_code = ERR_NONE;
      cmd_not    = (cmd_opcode == OP_NOT);
      case (cmd)
         CMD_PUSH: if (count == CW'(DEPTH)) check_code = ERR_OVF;
         CMD_POP:  if (count == '0) check_code = ERR_UNF;
         CMD_EXEC: begin
            if (cmd_opcode < OP_FIRST || cmd_opcode > OP_LAST)
               check_code = ERR_BADOP;
            else if (cmd_not ? (count == '0) : (count < CW'(2)))
               check_code = ERR_UNF;
         end
         default: ;
      endcase
   end

   assign push_ok = accept && (cmd == CMD_PUSH) && (check_code == ERR_NONE);

   // An empty stack shows 0 on top, which hides whatever storage still holds.
   always_comb begin
      top = '0;
      if (count != '0) top = mem[top_idx];
   end

   // Entry storage is not reset. It is written by a good PUSH, and by the
   // WRITE step of EXEC. NOT overwrites the top entry. A binary op writes the
   // second entry, and the top is dropped by the count decrement.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[push_idx] <= push_data;
      else if (state == WRITE)
         mem[(alu_opcode == OP_NOT) ? top_idx : sec_idx] <= result_q;
   end

   // Control FSM. IDLE handles PUSH, POP, NOP and error reporting. An accepted
   // EXEC latches its operands and opcode. EXEC samples the ALU, and WRITE
   // commits the result. Reset abandons any EXEC that is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         result_q   <= '0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (check_code != ERR_NONE) begin
                     err      <= 1'b1;
                     err_code <= check_code;
                  end else begin
                     err_code <= ERR_NONE;
                     case (cmd)
                        CMD_PUSH: count <= count + CW'(1);
                        CMD_POP:  count <= count - CW'(1);
                        CMD_EXEC: begin
                           alu_a      <= cmd_not ? mem[top_idx] : mem[sec_idx];
                           alu_b      <= cmd_not ? '0 : mem[top_idx];
                           alu_opcode <= cmd_opcode;
                           state      <= EXEC;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            EXEC: begin
               result_q <= alu_result;
               state    <= WRITE;
            end
            WRITE: begin
               if (alu_opcode != OP_NOT) count <= count - CW'(1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_stack.sv
// -----------------------------------------------------------------------------
// tb_operand_stack
//
// Self-checking bench for operand_stack. A queue-based reference stack holds
// the expected contents and error code. A behavioural ALU answers the DUT's
// operand requests, and the same ALU supplies the expected EXEC results.
// -----------------------------------------------------------------------------
module tb_operand_stack;

   localparam int DW    = 11;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rstN;
   logic          cmdValid;
   logic          cmdReady;
   logic [1:0]    cmd;
   logic [DW-1:0] pushData;
   logic [3:0]    cmdOpcode;
   logic [DW-1:0] aluA;
   logic [DW-1:0] aluB;
   logic [3:0]    aluOpcode;
   logic [DW-1:0] aluResult;
   logic [DW-1:0] top;
   logic [CW-1:0] count;
   logic          err;
   logic [1:0]    errCode;

   int            vectorCount = 0;
   int            miscompareCount = 0;
   logic [DW-1:0] refStack[$];
   logic [1:0]    refCode = 2'd0;

   operand_stack #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rstN),
      .cmd_valid  (cmdValid),
      .cmd_ready  (cmdReady),
      .cmd        (cmd),
      .push_data  (pushData),
      .cmd_opcode (cmdOpcode),
      .alu_a      (aluA),
      .alu_b      (aluB),
      .alu_opcode (aluOpcode),
      .alu_result (aluResult),
      .top        (top),
      .count      (count),
      .err        (err),
      .err_code   (errCode)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Behavioural ALU: 4 add, 5 sub, 6 mul, 7 and, 8 or, 9 xor, 10 shl, 11 shr,
   // 12 compare (a<b -> all ones, a==b -> 0, else 1), 13 logical not
   function automatic logic [DW-1:0] aluFn(input logic [3:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] r;
      x = 32'(a);
      y = 32'(b);
      case (op)
         4'd4:  r = x + y;
         4'd5:  r = x - y;
         4'd6:  r = x * y;
         4'd7:  r = x & y;
         4'd8:  r = x | y;
         4'd9:  r = x ^ y;
         4'd10: r = x << (y % 16);
         4'd11: r = x >> (y % 16);
         4'd12: r = (x < y) ? 32'hFFFF_FFFF : ((x == y) ? 32'd0 : 32'd1);
         4'd13: r = (x == 0) ? 32'd1 : 32'd0;
         default: r = 32'd0;
      endcase
      return r[DW-1:0];
   endfunction

   // The ALU environment reacts combinationally to the DUT's registered operands
   always_comb aluResult = aluFn(aluOpcode, aluA, aluB);

   function automatic logic [DW-1:0] refTop();
      if (refStack.size() == 0) return '0;
      return refStack[refStack.size()-1];
   endfunction

   // Count one comparison and report it if it does not match
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Offer one command, then step the reference model and check the outcome.
   // A good EXEC is followed through EXEC and WRITE to the updated stack.
   // An error is followed one extra cycle to confirm that err is a single pulse.
   task automatic applyStimulus(input logic [1:0] c, input logic [DW-1:0] d,
                                input logic [3:0] op);
      int            waitCycles;
      int            sz;
      logic [1:0]    code;
      logic          execOk;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] r;
      @(negedge clk);
      waitCycles = 0;
      while (!cmdReady && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("cmd_ready_idle", 32'(cmdReady), 32'd1);

      sz   = refStack.size();
      code = 2'd0;
      case (c)
         2'd1: if (sz == DEPTH) code = 2'd1;
         2'd2: if (sz == 0) code = 2'd2;
         2'd3: begin
            if (op < 4 || op > 13) code = 2'd3;
            else if (op == 13 ? (sz == 0) : (sz < 2)) code = 2'd2;
         end
         default: ;
      endcase
      execOk = (c == 2'd3) && (code == 2'd0);
      a = '0;
      b = '0;
      if (execOk) begin
         a = (op == 13) ? refStack[sz-1] : refStack[sz-2];
         b = (op == 13) ? '0 : refStack[sz-1];
      end

      cmdValid  = 1'b1;
      cmd       = c;
      pushData  = d;
      cmdOpcode = op;
      @(posedge clk);
      #1;
      cmdValid  = 1'b0;
      cmd       = 2'($urandom_range(0, 3));
      pushData  = DW'($urandom);
      cmdOpcode = 4'($urandom_range(0, 15));

      if (code != 2'd0) refCode = code;
      else begin
         refCode = 2'd0;
         if (c == 2'd1) refStack.push_back(d);
         else if (c == 2'd2) void'(refStack.pop_back());
      end

      @(negedge clk);
      checkOutput("err", 32'(err), 32'(code != 2'd0));
      checkOutput("err_code", 32'(errCode), 32'(refCode));
      if (execOk) begin
         checkOutput("alu_a", 32'(aluA), 32'(a));
         checkOutput("alu_b", 32'(aluB), 32'(b));
         checkOutput("alu_opcode", 32'(aluOpcode), 32'(op));
         checkOutput("cmd_ready_exec", 32'(cmdReady), 32'd0);
         @(negedge clk);
         checkOutput("cmd_ready_write", 32'(cmdReady), 32'd0);
         @(negedge clk);
         r = aluFn(op, a, b);
         if (op == 13) refStack[refStack.size()-1] = r;
         else begin
            void'(refStack.pop_back());
            void'(refStack.pop_back());
            refStack.push_back(r);
         end
         checkOutput("err_after_exec", 32'(err), 32'd0);
      end
      checkOutput("top", 32'(top), 32'(refTop()));
      checkOutput("count", 32'(count), 32'(refStack.size()));
      if (code != 2'd0) begin
         @(negedge clk);
         checkOutput("err_pulse_end", 32'(err), 32'd0);
         checkOutput("err_code_hold", 32'(errCode), 32'(refCode));
      end
   endtask

   // Directed scenarios first, then a randomized stream against the model
   initial begin
      rstN      = 1'b0;
      cmdValid  = 1'b0;
      cmd       = 2'd0;
      pushData  = '0;
      cmdOpcode = 4'd0;

      #12;
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_top", 32'(top), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_err_code", 32'(errCode), 32'd0);
      checkOutput("rst_alu_a", 32'(aluA), 32'd0);
      checkOutput("rst_alu_b", 32'(aluB), 32'd0);
      checkOutput("rst_alu_opcode", 32'(aluOpcode), 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      #1;
      checkOutput("rst_ready", 32'(cmdReady), 32'd1);

      // 10 + 20
      applyStimulus(2'd1, 11'd10, 4'd0);
      applyStimulus(2'd1, 11'd20, 4'd0);
      applyStimulus(2'd3, 11'd0, 4'd4);
      checkOutput("add_top", 32'(top), 32'd30);
      checkOutput("add_count", 32'(count), 32'd1);
      applyStimulus(2'd2, 11'd0, 4'd0);

      // 20 - 10, then 24 * 25
      applyStimulus(2'd1, 11'd20, 4'd0);
      applyStimulus(2'd1, 11'd10, 4'd0);
      applyStimulus(2'd3, 11'd0, 4'd5);
      checkOutput("sub_top", 32'(top), 32'd10);
      applyStimulus(2'd2, 11'd0, 4'd0);
      applyStimulus(2'd1, 11'd24, 4'd0);
      applyStimulus(2'd1, 11'd25, 4'd0);
      applyStimulus(2'd3, 11'd0, 4'd6);
      checkOutput("mul_top", 32'(top), 32'd600);
      applyStimulus(2'd2, 11'd0, 4'd0);

      // compare 123 < 124, then NOT of a lone 123
      applyStimulus(2'd1, 11'd123, 4'd0);
      applyStimulus(2'd1, 11'd124, 4'd0);
      applyStimulus(2'd3, 11'd0, 4'd12);
      checkOutput("cmp_top", 32'(top), 32'h7FF);
      checkOutput("cmp_count", 32'(count), 32'd1);
      applyStimulus(2'd2, 11'd0, 4'd0);
      applyStimulus(2'd1, 11'd123, 4'd0);
      applyStimulus(2'd3, 11'd0, 4'd13);
      checkOutput("not_top", 32'(top), 32'd0);
      checkOutput("not_count", 32'(count), 32'd1);
      applyStimulus(2'd2, 11'd0, 4'd0);

      // Fill to capacity, then one push too many
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(2'd1, DW'($urandom), 4'd0);
      applyStimulus(2'd1, 11'h555, 4'd0);
      checkOutput("ovf_code", 32'(errCode), 32'd1);
      checkOutput("ovf_count", 32'(count), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(2'd2, 11'd0, 4'd0);

      // Underflow and bad opcode
      applyStimulus(2'd2, 11'd0, 4'd0);
      checkOutput("unf_pop_code", 32'(errCode), 32'd2);
      applyStimulus(2'd1, 11'd5, 4'd0);
      applyStimulus(2'd3, 11'd0, 4'd4);
      checkOutput("unf_exec_code", 32'(errCode), 32'd2);
      applyStimulus(2'd3, 11'd0, 4'd2);
      checkOutput("badop_code", 32'(errCode), 32'd3);
      checkOutput("badop_top", 32'(top), 32'd5);
      checkOutput("badop_count", 32'(count), 32'd1);
      applyStimulus(2'd0, 11'd0, 4'd0);
      checkOutput("nop_clears_code", 32'(errCode), 32'd0);
      applyStimulus(2'd2, 11'd0, 4'd0);

      // Reset while an EXEC is in flight
      applyStimulus(2'd1, 11'd7, 4'd0);
      applyStimulus(2'd1, 11'd9, 4'd0);
      @(negedge clk);
      cmdValid  = 1'b1;
      cmd       = 2'd3;
      cmdOpcode = 4'd4;
      @(posedge clk);
      #1;
      cmdValid = 1'b0;
      #2;
      rstN = 1'b0;
      #1;
      refStack.delete();
      refCode = 2'd0;
      checkOutput("midrst_count", 32'(count), 32'd0);
      checkOutput("midrst_top", 32'(top), 32'd0);
      checkOutput("midrst_err", 32'(err), 32'd0);
      checkOutput("midrst_ready", 32'(cmdReady), 32'd1);
      checkOutput("midrst_alu_a", 32'(aluA), 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("postrst_count", 32'(count), 32'd0);
      checkOutput("postrst_top", 32'(top), 32'd0);
      checkOutput("postrst_err_code", 32'(errCode), 32'd0);
      applyStimulus(2'd1, 11'd3, 4'd0);
      checkOutput("postrst_push", 32'(top), 32'd3);

      // Randomized command stream
      for (int i = 0; i < 300; i++) begin
         logic [3:0] op;
         op = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(4, 13))
                                          : 4'($urandom_range(0, 15));
         applyStimulus(2'($urandom_range(0, 3)), DW'($urandom), op);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 The module SHALL have parameter DATA_SIZE, default 11, giving the stack word and ALU operand width.
REQ-002 The module SHALL have parameter DEPTH, default 16, giving the number of stack entries (power of two, >=2).
REQ-003 The module SHALL have input clk, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have input rst_n, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have input cmd_valid, 1 bit, meaning a command is offered.
REQ-006 The module SHALL have output cmd_ready, 1 bit, meaning a command can be accepted this cycle.
REQ-007 The module SHALL have input cmd, 2 bits, with encoding 0=NOP, 1=PUSH, 2=POP, 3=EXEC.
REQ-008 The module SHALL have input push_data, DATA_SIZE bits, the value pushed on PUSH.
REQ-009 The module SHALL have input cmd_opcode, 4 bits, the ALU opcode used on EXEC.
REQ-010 The module SHALL have outputs alu_a and alu_b, DATA_SIZE bits each, and alu_opcode, 4 bits, which drive the ALU.
REQ-011 The module SHALL have input alu_result, DATA_SIZE bits, the combinational ALU output.
REQ-012 The module SHALL have output top, DATA_SIZE bits, giving the top-of-stack value, or 0 when empty.
REQ-013 The module SHALL have output count, $clog2(DEPTH+1) bits, giving the number of valid entries.
REQ-014 The module SHALL have outputs err, 1 bit, a one-cycle error pulse, and err_code, 2 bits, with encoding 0=none, 1=overflow, 2=underflow, 3=bad opcode.

Function
REQ-015 A command SHALL be accepted in any cycle where cmd_valid and cmd_ready are both 1; no other cycle has effect.
REQ-016 The module SHALL use FSM states IDLE, EXEC and WRITE; cmd_ready SHALL be 1 only in IDLE.
REQ-017 An accepted PUSH with count<DEPTH SHALL write push_data at the top and increment count at that edge; latency 1 cycle; state stays IDLE.
REQ-018 An accepted POP with count>0 SHALL decrement count at that edge; the popped value is discarded.
REQ-019 An accepted NOP SHALL change nothing.
REQ-020 An accepted EXEC with valid operands SHALL transition IDLE->EXEC.
REQ-021 On that EXEC acceptance edge, the module SHALL register alu_a=entry[count-2] (second from top), alu_b=entry[count-1] (top), and alu_opcode=cmd_opcode.
REQ-022 For NOT (13), EXEC SHALL use alu_a=top and alu_b=0.
REQ-023 In state EXEC, the module SHALL capture alu_result into a result register and move to WRITE.
REQ-024 In state WRITE, a binary op SHALL replace the two operands with the result (count-1); NOT SHALL replace the top (count unchanged); the FSM then returns to IDLE.
REQ-025 EXEC total latency SHALL be 3 cycles from acceptance to the updated top/count, and the next command is accepted the cycle after WRITE.
REQ-026 Valid EXEC opcodes SHALL be 4..13; opcodes 0-3 and 14-15 SHALL produce err_code=3.
REQ-027 Errors SHALL be detected at acceptance: PUSH at count==DEPTH gives code 1; POP at count==0, binary EXEC at count<2, or NOT at count==0 gives code 2.
REQ-028 On any error, the stack SHALL be unchanged, the FSM SHALL stay IDLE, err SHALL be 1 for the following cycle only, and err_code SHALL hold until the next accepted command.
REQ-029 Each successful accepted command SHALL clear err_code to 0.
REQ-030 When the stack is full or empty, the boundary SHALL be handled only through REQ-027; the stack pointer SHALL never wrap.
REQ-031 Outside EXEC/WRITE, alu_a, alu_b and alu_opcode SHALL hold their last values.

Reset
REQ-032 While rst_n=0, regardless of clk, the module SHALL set state=IDLE, count=0, top=0, alu_a=0, alu_b=0, alu_opcode=0, err=0, err_code=0, and cmd_ready=1 after release.
REQ-033 A reset asserted in EXEC or WRITE SHALL abandon the operation, leave the stack empty, and not write the result.
REQ-034 Stack entry storage need not be cleared on reset; it SHALL be unobservable because top=0 when count=0.

Verification
REQ-035 Bench scenario: PUSH 10, PUSH 20, EXEC ADD(4) -> 3 cycles after acceptance top=30, count=1, err=0.
REQ-036 Bench scenario: PUSH 20, PUSH 10, EXEC SUB(5) -> top=10; then PUSH 25, EXEC MUL(6) with 24 below -> top=600 after PUSH 24 precedes.
REQ-037 Bench scenario: PUSH 123, PUSH 124, EXEC CMP(12) -> top=11'h7FF, count=1; PUSH 123 onto empty stack, EXEC NOT(13) -> top=0, count=1.
REQ-038 Bench scenario: DEPTH PUSHes, then one more PUSH -> err pulses 1 cycle, err_code=1, count=DEPTH, top unchanged.
REQ-039 Bench scenario: POP on empty, EXEC ADD with count=1, and EXEC opcode 2 -> err_code 2, 2, 3 respectively, with the stack unchanged.
REQ-040 Bench scenario: EXEC accepted then rst_n low during EXEC -> count=0, top=0, err=0 immediately, and no write after rst_n returns high.
